uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port uartrx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  last correctly received byte.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data newly valid.
REQ-007 SHALL have port rx_busy  output  1  high from start-bit detect until frame end.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch; tied 0 when parity is compiled out.

Function
REQ-010 SHALL pass uartrx through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: a synchronized low SHALL move to START, clear the bit counter and set rx_busy.
REQ-013 START: after CLKS_PER_BIT/2 cycles, the line SHALL be sampled; low moves to DATA, high (glitch) returns to IDLE without any pulse.
REQ-014 DATA: 8 bits SHALL be sampled at mid-bit (every CLKS_PER_BIT cycles after the start mid-sample), MSB first (team framing convention).
REQ-015 After bit 8, the FSM SHALL go to PARITY if enabled, else STOP.
REQ-016 STOP: at the mid-bit sample, high SHALL update rx_data and pulse rx_valid in the following cycle; low SHALL pulse frame_err, leave rx_data unchanged and suppress rx_valid.
REQ-017 After the stop sample, the FSM SHALL return to IDLE and drop rx_busy in the same cycle as the pulse.
REQ-018 A line still low in IDLE (break, or framing error) SHALL be treated as a new start bit.
REQ-019 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reload on every sample, and never wrap mid-bit.
REQ-020 rx_valid, frame_err and parity_err SHALL never be high for more than one cycle per frame.
REQ-021 Back-to-back frames with a one-bit stop SHALL be received with no lost byte.

Reset
REQ-022 While rst is high: state=IDLE, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0, counters=0, synchronizer flops=1.
REQ-023 rst asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the next falling edge after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: a 9th bit SHALL be sampled in PARITY and even parity checked over data plus parity bit.
REQ-025 On mismatch, parity_err SHALL pulse in the same cycle rx_valid would, rx_valid SHALL be suppressed and rx_data SHALL keep its old value; frame_err takes precedence if both occur.
REQ-026 Macro undefined: PARITY is unreachable, frames are 10 bits and parity_err=0.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum, DATA_BITS=8 and the idle line level constant.
REQ-028 The synchronizer SHALL be the sub-module uart_rx_sync (2 flops, reset to 1); all other logic stays in uart_rx.

Verification
REQ-029 CLKS_PER_BIT=16, send 8'hA5 with a valid stop -> rx_valid pulses once, rx_data=8'hA5, frame_err=0.
REQ-030 Send 8'h3C then 8'hC3 back-to-back -> two rx_valid pulses with rx_data 8'h3C then 8'hC3 in order.
REQ-031 Low glitch of 4 cycles on an idle line -> returns to IDLE, no pulses, rx_busy high at most 10 cycles.
REQ-032 Send 8'h55 with stop bit low -> frame_err pulses once, rx_valid=0, rx_data holds its previous value.
REQ-033 rst pulsed at data bit 4 -> all outputs at reset values; the next frame 8'h81 is received correctly.
REQ-034 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err pulses once, rx_valid=0; with parity bit 1 -> rx_valid pulses, rx_data=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional even parity is compiled in with the UART_RX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  // Even parity holds when data plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                          input logic                 par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to the idle line level so reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments make r_sync take r_meta's old value, giving two real stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits MSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to receive and check an even parity bit after the data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uartrx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic w_rx;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(uartrx),
    .o_sync (w_rx)
  );

  uart_state_e          r_state,   w_state_next;
  logic [BAUD_W-1:0]    r_baud,    w_baud_next;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_next;
  logic [DATA_BITS-1:0] r_shift,   w_shift_next;
  logic [DATA_BITS-1:0] r_data,    w_data_next;
  logic                 r_valid,   w_valid_next;
  logic                 r_ferr,    w_ferr_next;
  logic                 r_perr,    w_perr_next;
  logic                 r_busy,    w_busy_next;
  logic                 w_par_ok;

`ifdef UART_RX_PARITY_EN
  logic r_par, w_par_next;
  assign w_par_ok = even_parity_ok(r_shift, r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
      r_perr    <= w_perr_next;
      r_busy    <= w_busy_next;
`ifdef UART_RX_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

  always_comb begin
    // NOTE: every next value is defaulted first so no branch can leave one unassigned and infer a latch.
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
    w_perr_next  = 1'b0;
    w_busy_next  = r_busy;
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        // A line held low after a bad frame is simply taken as the next start bit.
        if (w_rx != LINE_IDLE) begin
          w_state_next = ST_START;
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_busy_next  = 1'b1;
        end
      end

      ST_START: begin
        if (r_baud == BAUD_HALF) begin
          w_baud_next = '0;
          if (w_rx != LINE_IDLE) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (r_baud == BAUD_FULL) begin
          w_baud_next  = '0;
          w_shift_next = {r_shift[DATA_BITS-2:0], w_rx};
          if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_bit_next = r_bit_cnt + BIT_W'(1);
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_baud == BAUD_FULL) begin
          w_baud_next  = '0;
          w_par_next   = w_rx;
          w_state_next = ST_STOP;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (r_baud == BAUD_FULL) begin
          w_baud_next  = '0;
          w_state_next = ST_IDLE;
          w_busy_next  = 1'b0;
          // A bad stop bit outranks a parity mismatch; either one keeps the old byte.
          if (w_rx != LINE_IDLE) begin
            w_ferr_next = 1'b1;
          end else if (!w_par_ok) begin
            w_perr_next = 1'b1;
          end else begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign rx_busy    = r_busy;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;

endmodule
